// File: rtl/pht_update_ctrl_pkg.sv
// Shared branch-predictor definitions: controller states, counter reset value
// and the 2-bit saturating counter update.
package pht_update_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT = 2'b00,
        IDLE = 2'b01,
        WR   = 2'b10
    } pht_state_e;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;

    function automatic logic [1:0] ctr_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Update buffer: power-of-two ring with one extra pointer bit to tell full from empty.
module pht_upd_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer and storage update; reset drops any buffered entries.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT sequencing controller: post-reset clear sweep, buffered counter updates
// as read-modify-write cycles, and a read port shared with fetch lookups.
module pht_update_ctrl
    import pht_update_ctrl_pkg::*;
#(
    parameter int IDX_W      = 3,
    parameter int CTR_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [IDX_W-1:0] f_idx,
    output logic             f_pred,
    output logic             f_valid,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic [IDX_W-1:0] pht_raddr,
    input  logic [CTR_W-1:0] pht_rdata,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_waddr,
    output logic [CTR_W-1:0] pht_wdata,
    output logic             init_done
);

    localparam int ENT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    pht_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             we_q, we_d;
    logic [IDX_W-1:0] waddr_q, waddr_d;
    logic [CTR_W-1:0] wdata_q, wdata_d;
    logic             init_done_q, init_done_d;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_pop_s;
    logic             fifo_push_s;
    logic [ENT_W-1:0] fifo_head_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_taken_s;

    assign head_idx_s   = fifo_head_s[ENT_W-1:1];
    assign head_taken_s = fifo_head_s[0];
    assign upd_ready    = !fifo_full_s && init_done_q;
    assign fifo_push_s  = upd_valid && upd_ready;

    assign pht_raddr = f_req ? f_idx : head_idx_s;
    assign f_valid   = f_req && init_done_q;
    assign f_pred    = f_valid && pht_rdata[CTR_W-1];
    assign pht_we    = we_q;
    assign pht_waddr = waddr_q;
    assign pht_wdata = wdata_q;
    assign init_done = init_done_q;

    pht_upd_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n_i (reset),
        .push_i  (fifo_push_s),
        .wdata_i ({upd_idx, upd_taken}),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state and write-port staging; the write lands the cycle after it is staged.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;
        fifo_pop_s  = 1'b0;
        case (state_q)
            INIT: begin
                we_d    = 1'b1;
                waddr_d = sweep_q;
                wdata_d = CTR_WEAK_NT;
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    state_d = INIT;
                end
            end
            IDLE: begin
                init_done_d = 1'b1;
                // Fetch owns the read port whenever it asks for it.
                if (!fifo_empty_s && !f_req) begin
                    fifo_pop_s = 1'b1;
                    we_d       = 1'b1;
                    waddr_d    = head_idx_s;
                    wdata_d    = ctr_sat_update(pht_rdata, head_taken_s);
                    state_d    = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Controller registers; reset abandons any staged write and restarts the sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Self-checking bench for pht_update_ctrl: table-driven counter updates, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_pht_update_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       f_req = 1'b0;
    logic [2:0] f_idx = 3'd0;
    logic       f_pred, f_valid;
    logic       upd_valid = 1'b0;
    logic [2:0] upd_idx = 3'd0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic [2:0] pht_raddr;
    logic [1:0] pht_rdata;
    logic       pht_we;
    logic [2:0] pht_waddr;
    logic [1:0] pht_wdata;
    logic       init_done;

    always #5 clk = ~clk;

    pht_update_ctrl #(.IDX_W(3), .CTR_W(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .f_req(f_req), .f_idx(f_idx), .f_pred(f_pred),
        .f_valid(f_valid), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .pht_raddr(pht_raddr), .pht_rdata(pht_rdata), .pht_we(pht_we),
        .pht_waddr(pht_waddr), .pht_wdata(pht_wdata), .init_done(init_done)
    );

    // Table storage: combinational read, write on clock; scrambled while in reset.
    logic [1:0] mem [8];
    assign pht_rdata = mem[pht_raddr];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 2'b11;
        end else if (pht_we) begin
            mem[pht_waddr] <= pht_wdata;
        end
    end

    typedef struct packed { logic [2:0] idx; logic taken; } upd_t;
    typedef struct { logic [2:0] idx; logic taken; logic [1:0] exp_wdata; logic exp_pred; } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         k;
    bit         m_rst;
    logic       m_wr_valid;
    logic [2:0] m_wr_addr;
    logic [1:0] m_wr_data;
    logic [1:0] m_tbl [8];
    upd_t       q [$];

    logic       obs_we, obs_ready, obs_done, obs_fpred;
    logic [2:0] obs_waddr;
    logic [1:0] obs_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] ctr, input logic taken);
        int c;
        c = int'(ctr);
        if (taken) c = (c + 1 > 3) ? 3 : c + 1;
        else       c = (c - 1 < 0) ? 0 : c - 1;
        return 2'(c);
    endfunction

    task automatic cycle(input logic fr, input logic [2:0] fi, input logic uv,
                         input logic [2:0] ui, input logic ut);
        logic e_ready, e_done, e_we, e_fv, e_fp, pop_now;
        logic [2:0] e_waddr;
        logic [1:0] e_wdata;
        upd_t h;
        f_req = fr; f_idx = fi; upd_valid = uv; upd_idx = ui; upd_taken = ut;
        @(negedge clk);
        if (m_rst) begin
            e_done = 1'b0; e_ready = 1'b0; e_we = 1'b0; e_waddr = 3'd0; e_wdata = 2'd0;
        end else begin
            e_done  = (k >= 9);
            e_ready = e_done && (q.size() < 4);
            if (k >= 1 && k <= 8) begin
                e_we = 1'b1; e_waddr = 3'(k - 1); e_wdata = 2'b01;
            end else if (m_wr_valid) begin
                e_we = 1'b1; e_waddr = m_wr_addr; e_wdata = m_wr_data;
            end else begin
                e_we = 1'b0; e_waddr = 3'd0; e_wdata = 2'd0;
            end
        end
        e_fv = fr && e_done;
        e_fp = e_fv ? m_tbl[fi][1] : 1'b0;
        obs_we = pht_we; obs_waddr = pht_waddr; obs_wdata = pht_wdata;
        obs_ready = upd_ready; obs_done = init_done; obs_fpred = f_pred;
        chk("upd_ready", 32'(upd_ready), 32'(e_ready));
        chk("init_done", 32'(init_done), 32'(e_done));
        chk("f_valid", 32'(f_valid), 32'(e_fv));
        chk("f_pred", 32'(f_pred), 32'(e_fp));
        chk("pht_we", 32'(pht_we), 32'(e_we));
        if (e_we) begin
            chk("pht_waddr", 32'(pht_waddr), 32'(e_waddr));
            chk("pht_wdata", 32'(pht_wdata), 32'(e_wdata));
        end
        if (!m_rst && fr) chk("pht_raddr_fetch", 32'(pht_raddr), 32'(fi));
        else if (!m_rst && q.size() > 0) chk("pht_raddr_upd", 32'(pht_raddr), 32'(q[0].idx));
        pop_now = !m_rst && !m_wr_valid && (q.size() > 0) && !fr && (k >= 8);
        @(posedge clk);
        if (!m_rst) begin
            if (m_wr_valid) m_tbl[m_wr_addr] = m_wr_data;
            m_wr_valid = pop_now;
            if (pop_now) begin
                h = q.pop_front();
                m_wr_addr = h.idx;
                m_wr_data = sat(m_tbl[h.idx], h.taken);
            end
            if (uv && e_ready) begin
                h.idx = ui; h.taken = ut;
                q.push_back(h);
            end
            if (k < 1000) k++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    // Releases reset and verifies a complete 8-write clear sweep.
    task automatic release_and_sweep();
        int nwr;
        reset = 1'b1;
        m_rst = 1'b0; k = 0; m_wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 2'b01;
        nwr = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            if (obs_we) nwr++;
        end
        chk("sweep_write_count", 32'(nwr), 32'd8);
        chk("sweep_init_done", 32'(obs_done), 32'd1);
        chk("sweep_upd_ready", 32'(obs_ready), 32'd1);
    endtask

    vec_t vecs [8];
    int   nwr;
    logic [2:0] waddrs [$];

    initial begin
        vecs[0] = '{3'd5, 1'b1, 2'b10, 1'b1};
        vecs[1] = '{3'd2, 1'b1, 2'b10, 1'b1};
        vecs[2] = '{3'd2, 1'b1, 2'b11, 1'b1};
        vecs[3] = '{3'd2, 1'b1, 2'b11, 1'b1};
        vecs[4] = '{3'd2, 1'b0, 2'b10, 1'b1};
        vecs[5] = '{3'd2, 1'b0, 2'b01, 1'b0};
        vecs[6] = '{3'd2, 1'b0, 2'b00, 1'b0};
        vecs[7] = '{3'd2, 1'b0, 2'b00, 1'b0};

        m_rst = 1'b1; k = 0; m_wr_valid = 1'b0; m_wr_addr = 3'd0; m_wr_data = 2'd0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 2'b01;

        // Reset values, including a fetch request held during reset
        cycle(1'b1, 3'd3, 1'b1, 3'd1, 1'b1);
        cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        release_and_sweep();

        // Table-driven counter updates, each followed by a lookup of that entry
        foreach (vecs[i]) begin
            cycle(1'b0, 3'd0, 1'b1, vecs[i].idx, vecs[i].taken);
            idle(1);
            idle(1);
            chk("vec_we", 32'(obs_we), 32'd1);
            chk("vec_waddr", 32'(obs_waddr), 32'(vecs[i].idx));
            chk("vec_wdata", 32'(obs_wdata), 32'(vecs[i].exp_wdata));
            cycle(1'b1, vecs[i].idx, 1'b0, 3'd0, 1'b0);
            chk("vec_pred", 32'(obs_fpred), 32'(vecs[i].exp_pred));
        end

        // Fetch priority: six fetch cycles hold off a queued update
        nwr = 0;
        cycle(1'b1, 3'd1, 1'b1, 3'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3'(i), 1'b0, 3'd0, 1'b0);
            if (obs_we) nwr++;
        end
        chk("prio_no_write", 32'(nwr), 32'd0);
        idle(1);
        chk("prio_pop_cycle_we", 32'(obs_we), 32'd0);
        idle(1);
        chk("prio_write_we", 32'(obs_we), 32'd1);
        chk("prio_write_addr", 32'(obs_waddr), 32'd3);

        // FIFO full under fetch pressure, then in-order drain
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 3'd0, 1'b1, 3'(4 + i), 1'(i % 2));
            chk("full_push_ready", 32'(obs_ready), 32'd1);
        end
        cycle(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        chk("full_ready_low", 32'(obs_ready), 32'd0);
        waddrs.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            if (i == 0) chk("full_pop_cycle_ready", 32'(obs_ready), 32'd0);
            if (i == 1) chk("full_ready_reasserted", 32'(obs_ready), 32'd1);
            if (obs_we) waddrs.push_back(obs_waddr);
        end
        chk("full_drain_count", 32'(waddrs.size()), 32'd4);
        for (int i = 0; i < waddrs.size() && i < 4; i++)
            chk("full_drain_order", 32'(waddrs[i]), 32'(4 + i));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        idle(12);

        // Reset during a write cycle, with a second update still buffered
        cycle(1'b0, 3'd0, 1'b1, 3'd1, 1'b1);
        cycle(1'b0, 3'd0, 1'b1, 3'd6, 1'b0);
        chk("midwr_in_write", 32'(pht_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("midwr_we_drop", 32'(pht_we), 32'd0);
        chk("midwr_ready_drop", 32'(upd_ready), 32'd0);
        chk("midwr_done_drop", 32'(init_done), 32'd0);
        m_rst = 1'b1; q.delete(); m_wr_valid = 1'b0;
        cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 3'd6, 1'b0, 3'd0, 1'b0);
        release_and_sweep();
        cycle(1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
        chk("midwr_entry_cleared", 32'(obs_fpred), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
